control_display_7seg_n: RTL and testbench

CONTROL_DISPLAY_7SEG_N -- requirements
Module: control_display_7seg_n

---
 rtl/ctl7seg_pkg.sv | 25 ++
 rtl/gen_tick_pwm.sv | 36 +++
 rtl/control_display_7seg_n.sv | 116 +++++++++++
 tb/tb_control_display_7seg_n.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ctl7seg_pkg.sv
// Shared definitions for the multiplexed 7-segment controller:
// active-high hex glyph table and segment bit positions.
package ctl7seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Entry n is the glyph for hex digit n, bit order g..a (bit0 = a).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/gen_tick_pwm.sv
// Slot timer: SUB_DIV clocks per PWM phase, 2^BRIGHT_BITS phases per slot.
// Flags the first and last cycle of each slot.
module gen_tick_pwm #(
    parameter int SUB_DIV     = 3125,
    parameter int BRIGHT_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   slot_start,
    output logic                   slot_wrap,
    output logic [BRIGHT_BITS-1:0] phase
);

    localparam int SW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

    logic [SW-1:0] sub_cnt;
    logic          sub_last;

    assign sub_last   = (sub_cnt == SW'(SUB_DIV - 1));
    assign slot_wrap  = sub_last && (phase == '1);
    assign slot_start = (sub_cnt == '0) && (phase == '0);

    // Phase rolls over naturally, so the slot counter is {phase, sub_cnt}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_cnt <= '0;
            phase   <= '0;
        end else if (sub_last) begin
            sub_cnt <= '0;
            phase   <= phase + 1'b1;
        end else begin
            sub_cnt <= sub_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/control_display_7seg_n.sv
// Multiplexed N-digit 7-segment driver with PWM brightness, frame-synchronous
// double buffering and leading-zero blanking.
module control_display_7seg_n
    import ctl7seg_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int SUB_DIV       = 3125,
    parameter int BRIGHT_BITS   = 4,
    parameter bit ANODE_ACT_LOW = 1'b1,
    parameter bit SEG_ACT_LOW   = 1'b1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [4*N_DIGITS-1:0]   i_Datos,
    input  logic [N_DIGITS-1:0]     i_Dp,
    input  logic                    i_Load,
    input  logic                    i_Blank_Lz,
    input  logic [BRIGHT_BITS-1:0]  i_Brillo,
    output logic [N_DIGITS-1:0]     o_Anodo,
    output logic [6:0]              o_Segmentos,
    output logic                    o_Dp,
    output logic                    o_Frame,
    output logic                    o_Pendiente
);

    localparam int IW = $clog2(N_DIGITS);
    localparam logic [N_DIGITS-1:0] AN_INV  = {N_DIGITS{ANODE_ACT_LOW}};
    localparam logic [6:0]          SEG_INV = {7{SEG_ACT_LOW}};

    logic                   slot_start, slot_wrap, frame_wrap;
    logic [BRIGHT_BITS-1:0] phase, bright_q, bright_eff;
    logic [IW-1:0]          idx;
    logic [4*N_DIGITS-1:0]  stage_data, disp_data;
    logic [N_DIGITS-1:0]    stage_dp, disp_dp, blank;
    logic [3:0]             cur_nib;
    logic                   cur_blank, lit;
    logic [N_DIGITS-1:0]    an_next;
    logic [6:0]             seg_next;
    logic                   dp_next;

    gen_tick_pwm #(.SUB_DIV(SUB_DIV), .BRIGHT_BITS(BRIGHT_BITS)) u_tick (
        .clk        (i_Clk),
        .rst_n      (i_Rst),
        .slot_start (slot_start),
        .slot_wrap  (slot_wrap),
        .phase      (phase)
    );

    assign frame_wrap = slot_wrap && (idx == IW'(N_DIGITS - 1));

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            idx      <= '0;
            bright_q <= '0;
            o_Frame  <= 1'b0;
        end else begin
            if (slot_start)
                bright_q <= i_Brillo;
            if (slot_wrap)
                idx <= frame_wrap ? '0 : idx + 1'b1;
            o_Frame <= frame_wrap;
        end
    end

    // Display only changes on the frame boundary; a load landing on that same
    // edge stages for the next frame while the older staging is shown.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            stage_data  <= '0;
            stage_dp    <= '0;
            disp_data   <= '0;
            disp_dp     <= '0;
            o_Pendiente <= 1'b0;
        end else begin
            if (i_Load) begin
                stage_data <= i_Datos;
                stage_dp   <= i_Dp;
            end
            if (frame_wrap && o_Pendiente) begin
                disp_data <= stage_data;
                disp_dp   <= stage_dp;
            end
            o_Pendiente <= i_Load || (o_Pendiente && !frame_wrap);
        end
    end

    assign blank[0] = 1'b0;
    for (genvar k = 1; k < N_DIGITS; k++) begin : g_blank
        assign blank[k] = i_Blank_Lz && (disp_data[4*N_DIGITS-1:4*k] == '0);
    end

    always_comb begin
        bright_eff = slot_start ? i_Brillo : bright_q;
        cur_nib    = disp_data[{idx, 2'b00} +: 4];
        cur_blank  = blank[idx];
        lit        = (phase <= bright_eff) && !cur_blank;
        an_next    = '0;
        an_next[idx] = lit;
        seg_next   = cur_blank ? 7'h00 : hex_to_seg(cur_nib);
        dp_next    = disp_dp[idx] && !cur_blank;
    end

    // Polarity is folded in only here; everything upstream is active-high.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            o_Anodo     <= AN_INV;
            o_Segmentos <= SEG_INV;
            o_Dp        <= SEG_ACT_LOW;
        end else begin
            o_Anodo     <= an_next ^ AN_INV;
            o_Segmentos <= seg_next ^ SEG_INV;
            o_Dp        <= dp_next ^ SEG_ACT_LOW;
        end
    end

endmodule

// File: tb/tb_control_display_7seg_n.sv
// Directed bench for the 4-digit, SUB_DIV=2, 2-bit brightness, active-low build.
module tb_control_display_7seg_n;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b0;
    logic [15:0] i_Datos = '0;
    logic [3:0]  i_Dp = '0;
    logic        i_Load = 1'b0;
    logic        i_Blank_Lz = 1'b0;
    logic [1:0]  i_Brillo = 2'd3;
    logic [3:0]  o_Anodo;
    logic [6:0]  o_Segmentos;
    logic        o_Dp, o_Frame, o_Pendiente;

    int n_vec = 0;
    int n_err = 0;

    control_display_7seg_n #(
        .N_DIGITS(4), .SUB_DIV(2), .BRIGHT_BITS(2),
        .ANODE_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
    ) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Datos(i_Datos), .i_Dp(i_Dp),
        .i_Load(i_Load), .i_Blank_Lz(i_Blank_Lz), .i_Brillo(i_Brillo),
        .o_Anodo(o_Anodo), .o_Segmentos(o_Segmentos), .o_Dp(o_Dp),
        .o_Frame(o_Frame), .o_Pendiente(o_Pendiente)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick;
        @(posedge i_Clk);
        #1;
    endtask

    function automatic logic [6:0] seg_hi(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic load(input logic [15:0] d, input logic [3:0] dp);
        i_Datos = d;
        i_Dp    = dp;
        i_Load  = 1'b1;
        tick;
        i_Load  = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 80 && !seen; c++) begin
            tick;
            if (o_Frame === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s frame_wait: no o_Frame within 80 cycles, need a pulse", tag);
        end
    endtask

    // Checks cycles j0..j1 of a frame; cycle j follows the frame edge by j+1 clocks.
    task automatic scan_frame(input string tag, input logic [15:0] d, input logic [3:0] dp,
                              input int j0, input int j1);
        for (int j = j0; j <= j1; j++) begin
            int dg, ph;
            logic blk;
            logic [3:0] exp_an;
            logic [6:0] exp_seg;
            logic exp_dp, exp_fr;
            tick;
            dg      = j / 8;
            ph      = (j % 8) / 2;
            blk     = (dg != 0) && i_Blank_Lz && ((d >> (4 * dg)) == 16'h0);
            exp_an  = (ph <= int'(i_Brillo) && !blk) ? ~(4'b0001 << dg) : 4'hF;
            exp_seg = blk ? 7'h7F : ~seg_hi(d[4*dg +: 4]);
            exp_dp  = blk ? 1'b1 : ~dp[dg];
            exp_fr  = (j == 31);
            n_vec++;
            if (o_Anodo !== exp_an) begin
                n_err++;
                $display("FAIL %s anode j=%0d: got %b need %b", tag, j, o_Anodo, exp_an);
            end
            n_vec++;
            if (o_Segmentos !== exp_seg) begin
                n_err++;
                $display("FAIL %s seg j=%0d: got %h need %h", tag, j, o_Segmentos, exp_seg);
            end
            n_vec++;
            if (o_Dp !== exp_dp) begin
                n_err++;
                $display("FAIL %s dp j=%0d: got %b need %b", tag, j, o_Dp, exp_dp);
            end
            n_vec++;
            if (o_Frame !== exp_fr) begin
                n_err++;
                $display("FAIL %s frame j=%0d: got %b need %b", tag, j, o_Frame, exp_fr);
            end
        end
    endtask

    task automatic test_reset;
        i_Rst = 1'b0;
        repeat (3) tick;
        n_vec++; if (o_Anodo !== 4'hF) begin n_err++; $display("FAIL rst_anode: got %b need 1111", o_Anodo); end
        n_vec++; if (o_Segmentos !== 7'h7F) begin n_err++; $display("FAIL rst_seg: got %h need 7f", o_Segmentos); end
        n_vec++; if (o_Dp !== 1'b1) begin n_err++; $display("FAIL rst_dp: got %b need 1", o_Dp); end
        n_vec++; if (o_Frame !== 1'b0) begin n_err++; $display("FAIL rst_frame: got %b need 0", o_Frame); end
        n_vec++; if (o_Pendiente !== 1'b0) begin n_err++; $display("FAIL rst_pend: got %b need 0", o_Pendiente); end
        i_Rst = 1'b1;
        tick;
        n_vec++; if (o_Anodo !== 4'b1110) begin n_err++; $display("FAIL first_anode: got %b need 1110", o_Anodo); end
        n_vec++; if (o_Segmentos !== 7'h40) begin n_err++; $display("FAIL first_seg: got %h need 40", o_Segmentos); end
    endtask

    task automatic test_scan;
        i_Brillo = 2'd3;
        load(16'h1234, 4'b0010);
        n_vec++; if (o_Pendiente !== 1'b1) begin n_err++; $display("FAIL scan_pend_set: got %b need 1", o_Pendiente); end
        wait_frame("scan");
        n_vec++; if (o_Pendiente !== 1'b0) begin n_err++; $display("FAIL scan_pend_clr: got %b need 0", o_Pendiente); end
        scan_frame("scan", 16'h1234, 4'b0010, 0, 31);
    endtask

    task automatic test_brightness;
        i_Brillo = 2'd0;
        scan_frame("bright0", 16'h1234, 4'b0010, 0, 31);
        i_Brillo = 2'd2;
        scan_frame("bright2", 16'h1234, 4'b0010, 0, 31);
    endtask

    task automatic test_tear;
        i_Brillo = 2'd3;
        load(16'hABCD, 4'b0100);
        n_vec++; if (o_Pendiente !== 1'b1) begin n_err++; $display("FAIL tear_pend_set: got %b need 1", o_Pendiente); end
        scan_frame("tear_old", 16'h1234, 4'b0010, 1, 31);
        n_vec++; if (o_Pendiente !== 1'b0) begin n_err++; $display("FAIL tear_pend_clr: got %b need 0", o_Pendiente); end
        scan_frame("tear_new", 16'hABCD, 4'b0100, 0, 31);
    endtask

    task automatic test_collision;
        load(16'h5678, 4'b0000);
        scan_frame("coll_pre", 16'hABCD, 4'b0100, 1, 30);
        i_Datos = 16'h1111;
        i_Dp    = 4'b1111;
        i_Load  = 1'b1;
        tick;
        i_Load  = 1'b0;
        n_vec++; if (o_Frame !== 1'b1) begin n_err++; $display("FAIL coll_frame: got %b need 1", o_Frame); end
        n_vec++; if (o_Pendiente !== 1'b1) begin n_err++; $display("FAIL coll_pend: got %b need 1", o_Pendiente); end
        scan_frame("coll_prior", 16'h5678, 4'b0000, 0, 31);
        n_vec++; if (o_Pendiente !== 1'b0) begin n_err++; $display("FAIL coll_pend_clr: got %b need 0", o_Pendiente); end
        scan_frame("coll_new", 16'h1111, 4'b1111, 0, 31);
    endtask

    task automatic test_blanking;
        i_Blank_Lz = 1'b1;
        load(16'h0050, 4'b1111);
        scan_frame("blank_pre", 16'h1111, 4'b1111, 1, 31);
        scan_frame("blank_0050", 16'h0050, 4'b1111, 0, 31);
        load(16'h0000, 4'b0001);
        scan_frame("blank_pre2", 16'h0050, 4'b1111, 1, 31);
        scan_frame("blank_0000", 16'h0000, 4'b0001, 0, 31);
    endtask

    task automatic test_reset_mid;
        load(16'h9999, 4'b1111);
        tick;
        #2 i_Rst = 1'b0;
        #1;
        n_vec++; if (o_Anodo !== 4'hF) begin n_err++; $display("FAIL mid_rst_anode: got %b need 1111", o_Anodo); end
        n_vec++; if (o_Segmentos !== 7'h7F) begin n_err++; $display("FAIL mid_rst_seg: got %h need 7f", o_Segmentos); end
        n_vec++; if (o_Dp !== 1'b1) begin n_err++; $display("FAIL mid_rst_dp: got %b need 1", o_Dp); end
        n_vec++; if (o_Pendiente !== 1'b0) begin n_err++; $display("FAIL mid_rst_pend: got %b need 0", o_Pendiente); end
        tick;
        i_Rst = 1'b1;
        tick;
        n_vec++; if (o_Anodo !== 4'b1110) begin n_err++; $display("FAIL mid_first_anode: got %b need 1110", o_Anodo); end
        n_vec++; if (o_Segmentos !== 7'h40) begin n_err++; $display("FAIL mid_first_seg: got %h need 40", o_Segmentos); end
        n_vec++; if (o_Dp !== 1'b1) begin n_err++; $display("FAIL mid_first_dp: got %b need 1", o_Dp); end
        wait_frame("mid");
        scan_frame("mid_cleared", 16'h0000, 4'b0000, 0, 31);
    endtask

    initial begin
        test_reset;
        test_scan;
        test_brightness;
        test_tear;
        test_collision;
        test_blanking;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
